// File: rtl/brnch_pred_pkg.sv
// Shared types and reset constants for the branch-predictor table update scheduler.
package brnch_pred_pkg;

  localparam int BP_IDX_W = 5;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_sched_state_t;

  typedef struct packed {
    logic [BP_IDX_W-1:0] addr;
    logic                taken;
  } bp_resolve_t;

  // LHT clears to an all-zero history; LPT clears to weakly-not-taken.
  localparam logic       LHT_RST_VAL = 1'b0;
  localparam logic [1:0] LPT_RST_VAL = 2'b01;

endpackage

// File: rtl/brnch_resolve_fifo.sv
// In-order resolution queue; a push and a pop may share a cycle even when full.
module brnch_resolve_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  assign dout  = mem[head];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/brnch_pred_upd_sched.sv
// Schedules writes to the single-ported LHT/LPT: init sweep, then queued updates
// issued in lookup-free cycles with a starvation override.
module brnch_pred_upd_sched
  import brnch_pred_pkg::*;
#(
  parameter int IDX_W      = 5,
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        resolve_valid,
  input  logic [IDX_W-1:0]            resolve_addr,
  input  logic                        resolve_taken,
  input  logic                        lookup_req,
  input  logic                        flush_req,
  output logic                        upd_en,
  output logic                        upd_clr,
  output logic [IDX_W-1:0]            upd_addr,
  output logic                        upd_taken,
  output logic                        lookup_blocked,
  output logic                        pred_ready,
  output logic                        q_full,
  output logic [$clog2(QDEPTH):0]     q_count,
  output logic [7:0]                  drop_cnt
);

  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  bp_sched_state_t state, state_nxt;
  logic [IDX_W-1:0] sweep_idx, sweep_nxt;
  logic [SW-1:0]    starve_cnt, starve_nxt;

  logic             q_empty;
  logic [IDX_W:0]   q_head;
  logic             issue;
  logic             accept;
  logic             push;
  logic             drop;

  brnch_resolve_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W (IDX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_req),
    .push  (push),
    .pop   (issue),
    .din   ({resolve_addr, resolve_taken}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_nxt      = state;
    sweep_nxt      = sweep_idx;
    starve_nxt     = starve_cnt;
    issue          = 1'b0;
    upd_en         = 1'b0;
    upd_clr        = 1'b0;
    upd_addr       = q_head[IDX_W:1];
    upd_taken      = 1'b0;
    lookup_blocked = 1'b0;
    pred_ready     = 1'b0;
    case (state)
      INIT: begin
        upd_en    = 1'b1;
        upd_clr   = 1'b1;
        upd_addr  = sweep_idx;
        upd_taken = LHT_RST_VAL;
        sweep_nxt = sweep_idx + 1'b1;
        if (flush_req)
          sweep_nxt = '0;
        else if (sweep_idx == {IDX_W{1'b1}})
          state_nxt = RUN;
      end
      RUN: begin
        pred_ready = 1'b1;
        if (q_empty) begin
          starve_nxt = '0;
        end else if (!lookup_req || starve_cnt == SW'(STARVE_LIM)) begin
          issue          = 1'b1;
          upd_en         = 1'b1;
          upd_taken      = q_head[0];
          lookup_blocked = lookup_req;
          starve_nxt     = '0;
        end else begin
          starve_nxt = starve_cnt + 1'b1;
        end
        if (flush_req) begin
          state_nxt  = INIT;
          sweep_nxt  = '0;
          starve_nxt = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign accept = (state == RUN) && resolve_valid && !flush_req;
  assign push   = accept && (!q_full || issue);
  assign drop   = accept && q_full && !issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      sweep_idx  <= '0;
      starve_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      sweep_idx  <= sweep_nxt;
      starve_cnt <= starve_nxt;
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

endmodule
